// File: rtl/mux_nto1_arb.sv
// ---------------------------------------------------------------------------
// mux_nto1_arb
// N-to-1 valid/ready multiplexer with one registered output stage.
// The channel is chosen either by a fixed select (i_sel) or by a
// round-robin arbiter that searches upward from a rotating pointer.
//
// Ports
//   i_clk    : clock, all state updates on the rising edge
//   i_rst    : synchronous active-high reset
//   i_data   : N_CH packed words, channel k in bits [k*WIDTH +: WIDTH]
//   i_valid  : per-channel valid
//   o_ready  : per-channel accept, one-hot or zero
//   i_mode   : 0 = fixed select via i_sel, 1 = round-robin
//   i_sel    : channel index used in fixed mode
//   o_data   : registered output word
//   o_valid  : o_data / o_ch hold a word
//   i_ready  : downstream accept
//   o_ch     : source channel of the word in o_data
// ---------------------------------------------------------------------------
module mux_nto1_arb #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  localparam int SELW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_CH*WIDTH-1:0]   i_data,
  input  logic [N_CH-1:0]         i_valid,
  output logic [N_CH-1:0]         o_ready,
  input  logic                    i_mode,
  input  logic [SELW-1:0]         i_sel,
  output logic [WIDTH-1:0]        o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [SELW-1:0]         o_ch
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  ch_q,   ch_d;
  logic             valid_q, valid_d;
  logic [SELW-1:0]  rr_q,   rr_d;

  logic             load_en;
  logic             gnt_vld;
  logic [SELW-1:0]  gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic             xfer;

  // The output register may accept a word when empty or being drained.
  assign load_en = !valid_q || i_ready;

  // Grant selection. A fixed select beyond N_CH-1 matches no channel, so it
  // naturally grants nothing.
  always_comb begin
    int c;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    c       = 0;
    if (!i_mode) begin
      for (int k = 0; k < N_CH; k++) begin
        if (i_sel == SELW'(k) && i_valid[k]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(k);
        end
      end
    end else begin
      // Search rr_q, rr_q+1, ... wrapping at N_CH-1; first hit wins.
      for (int off = 0; off < N_CH; off++) begin
        c = int'(rr_q) + off;
        if (c >= N_CH) c = c - N_CH;
        if (!gnt_vld && i_valid[c]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(c);
        end
      end
    end
  end

  // Data mux for the granted channel.
  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt_idx == SELW'(k)) gnt_data = i_data[k*WIDTH +: WIDTH];
    end
  end

  // Ready is suppressed during reset so no transfer can happen in that cycle.
  always_comb begin
    o_ready = '0;
    if (gnt_vld && load_en && !i_rst) begin
      for (int k = 0; k < N_CH; k++) begin
        if (gnt_idx == SELW'(k)) o_ready[k] = 1'b1;
      end
    end
  end

  // o_ready is only ever set for a valid channel, so any accepted bit is a transfer.
  assign xfer = |(i_valid & o_ready);

  always_comb begin
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    rr_d    = rr_q;
    if (xfer) begin
      data_d  = gnt_data;
      ch_d    = gnt_idx;
      valid_d = 1'b1;
      if (i_mode) begin
        rr_d = (int'(gnt_idx) == N_CH - 1) ? '0 : gnt_idx + 1'b1;
      end
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      rr_q    <= '0;
    end else begin
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      rr_q    <= rr_d;
    end
  end

  assign o_data  = data_q;
  assign o_ch    = ch_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_mux_nto1_arb.sv
// ---------------------------------------------------------------------------
// tb_mux_nto1_arb
// Directed bench for mux_nto1_arb: a table of per-cycle vectors for a
// 4-channel instance, plus a short sequence on a 3-channel instance for the
// out-of-range fixed select.
// ---------------------------------------------------------------------------
module tb_mux_nto1_arb;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic        rst;
  logic [31:0] data;
  logic [3:0]  valid;
  logic [3:0]  ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  odata;
  logic        ovalid;
  logic        iready;
  logic [1:0]  och;

  mux_nto1_arb #(.WIDTH(8), .N_CH(4)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
    .o_ready(ready), .i_mode(mode), .i_sel(sel), .o_data(odata),
    .o_valid(ovalid), .i_ready(iready), .o_ch(och)
  );

  // 3-channel instance
  logic        r3_rst;
  logic [23:0] r3_data;
  logic [2:0]  r3_valid;
  logic [2:0]  r3_ready;
  logic        r3_mode;
  logic [1:0]  r3_sel;
  logic [7:0]  r3_odata;
  logic        r3_ovalid;
  logic        r3_iready;
  logic [1:0]  r3_och;

  mux_nto1_arb #(.WIDTH(8), .N_CH(3)) u_dut3 (
    .i_clk(clk), .i_rst(r3_rst), .i_data(r3_data), .i_valid(r3_valid),
    .o_ready(r3_ready), .i_mode(r3_mode), .i_sel(r3_sel), .o_data(r3_odata),
    .o_valid(r3_ovalid), .i_ready(r3_iready), .o_ch(r3_och)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        iready;
    logic [3:0]  exp_ready;  // combinational, before the edge
    logic        exp_valid;  // after the edge
    logic [7:0]  exp_data;
    logic [1:0]  exp_ch;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic m, logic [1:0] s, logic [3:0] v,
                              logic [31:0] d, logic ir, logic [3:0] er,
                              logic ev, logic [7:0] ed, logic [1:0] ec);
    vec_t t;
    t.rst = r; t.mode = m; t.sel = s; t.valid = v; t.data = d; t.iready = ir;
    t.exp_ready = er; t.exp_valid = ev; t.exp_data = ed; t.exp_ch = ec;
    return t;
  endfunction

  localparam logic [31:0] ALL = 32'h13121110;

  initial begin
    // rst mode sel valid data iready | ready valid data ch
    vecs.push_back(mk(1, 1, 0, 4'hF, ALL,          1, 4'b0000, 0, 8'h00, 0)); // 0 reset
    vecs.push_back(mk(0, 0, 2, 4'h4, 32'h00A50000, 1, 4'b0100, 1, 8'hA5, 2)); // 1 fixed ch2
    vecs.push_back(mk(0, 1, 0, 4'hF, ALL,          1, 4'b0001, 1, 8'h10, 0)); // 2 rr
    vecs.push_back(mk(0, 1, 0, 4'hF, ALL,          1, 4'b0010, 1, 8'h11, 1)); // 3
    vecs.push_back(mk(0, 1, 0, 4'hF, ALL,          1, 4'b0100, 1, 8'h12, 2)); // 4
    vecs.push_back(mk(0, 1, 0, 4'hF, ALL,          1, 4'b1000, 1, 8'h13, 3)); // 5
    vecs.push_back(mk(0, 1, 0, 4'hF, ALL,          1, 4'b0001, 1, 8'h10, 0)); // 6 wrap, rr->1
    vecs.push_back(mk(0, 0, 1, 4'h2, 32'h00003C00, 1, 4'b0010, 1, 8'h3C, 1)); // 7 load 3C
    for (int i = 0; i < 5; i++)                                               // 8-12 stall
      vecs.push_back(mk(0, 1, 0, 4'hF, ALL,        0, 4'b0000, 1, 8'h3C, 1));
    vecs.push_back(mk(0, 1, 0, 4'hF, ALL,          1, 4'b0010, 1, 8'h11, 1)); // 13 no gap
    vecs.push_back(mk(0, 1, 0, 4'h4, ALL,          1, 4'b0100, 1, 8'h12, 2)); // 14 rr->3
    vecs.push_back(mk(0, 1, 0, 4'h2, ALL,          1, 4'b0010, 1, 8'h11, 1)); // 15 skip to ch1
    vecs.push_back(mk(0, 1, 0, 4'h0, ALL,          1, 4'b0000, 0, 8'h11, 1)); // 16 drain
    vecs.push_back(mk(0, 1, 0, 4'hF, ALL,          1, 4'b0100, 1, 8'h12, 2)); // 17 rr was 2
    vecs.push_back(mk(1, 1, 0, 4'hF, ALL,          0, 4'b0000, 0, 8'h00, 0)); // 18 reset mid
    vecs.push_back(mk(0, 1, 0, 4'hF, ALL,          1, 4'b0001, 1, 8'h10, 0)); // 19 from ch0
    vecs.push_back(mk(0, 0, 3, 4'hF, ALL,          0, 4'b0000, 1, 8'h10, 0)); // 20 mode chg held
    vecs.push_back(mk(0, 0, 3, 4'hF, ALL,          1, 4'b1000, 1, 8'h13, 3)); // 21 fixed ch3
    vecs.push_back(mk(0, 1, 0, 4'hF, ALL,          1, 4'b0010, 1, 8'h11, 1)); // 22 rr unchanged
    vecs.push_back(mk(0, 0, 0, 4'hE, ALL,          1, 4'b0000, 0, 8'h11, 1)); // 23 sel invalid

    rst = 1; data = '0; valid = '0; mode = 0; sel = 0; iready = 0;
    r3_rst = 1; r3_data = 24'h222120; r3_valid = '0; r3_mode = 0; r3_sel = 0;
    r3_iready = 0;
    repeat (2) @(posedge clk);
    #1;
    r3_rst = 0;

    foreach (vecs[i]) begin
      rst = vecs[i].rst; mode = vecs[i].mode; sel = vecs[i].sel;
      valid = vecs[i].valid; data = vecs[i].data; iready = vecs[i].iready;
      #1;
      chk("o_ready", i, 32'(ready), 32'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      chk("o_valid", i, 32'(ovalid), 32'(vecs[i].exp_valid));
      chk("o_data",  i, 32'(odata),  32'(vecs[i].exp_data));
      chk("o_ch",    i, 32'(och),    32'(vecs[i].exp_ch));
    end

    // Out-of-range fixed select on 3 channels: nothing may be granted.
    r3_mode = 0; r3_sel = 3; r3_valid = 3'b111; r3_iready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("n3_o_ready", i, 32'(r3_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("n3_o_valid", i, 32'(r3_ovalid), 32'd0);
    end
    // A legal select then transfers normally.
    r3_sel = 2;
    #1;
    chk("n3_o_ready", 3, 32'(r3_ready), 32'b100);
    @(posedge clk);
    #1;
    chk("n3_o_valid", 3, 32'(r3_ovalid), 32'd1);
    chk("n3_o_data",  3, 32'(r3_odata),  32'h22);
    chk("n3_o_ch",    3, 32'(r3_och),    32'd2);
    // Round-robin on 3 channels wraps 0,1,2,0.
    r3_mode = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("n3_rr_ch",   4 + i, 32'(r3_och),   32'(i % 3));
      chk("n3_rr_data", 4 + i, 32'(r3_odata), 32'(8'h20 + (i % 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
